// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with zero register, write bypass and pending scoreboard
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   RegWrite, WriteReg, WriteData      WB write port (also clears pending)
//   ReadReg1/2, ReadEn1/2              decode read ports and their use flags
//   IssueValid, IssueReg               decode issue, reserving IssueReg
//   ReadData1/2         combinational read data
//   Stall               combinational RAW/WAW hazard for the decode instruction
//   PendingCount        registered number of pending registers

module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic              ReadEn1,
    input  logic              ReadEn2,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueReg,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Stall,
    output logic [ADDR_W:0]   PendingCount
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pending_q, pending_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic wclr1, wclr2, wclr_iss;
    logic rhaz1, rhaz2, whaz;
    logic set_v, clr_v;

    // Register 0 is hardwired only when ZERO_REG is enabled.
    function automatic logic is_zero(input logic [ADDR_W-1:0] r);
        return (ZERO_REG != 0) && (r == '0);
    endfunction

    // Reads: zero register first, then same-cycle bypass, then storage.
    always_comb begin
        ReadData1 = regs_q[ReadReg1];
        ReadData2 = regs_q[ReadReg2];
        if ((BYPASS != 0) && RegWrite && (WriteReg == ReadReg1)) ReadData1 = WriteData;
        if ((BYPASS != 0) && RegWrite && (WriteReg == ReadReg2)) ReadData2 = WriteData;
        if (is_zero(ReadReg1)) ReadData1 = '0;
        if (is_zero(ReadReg2)) ReadData2 = '0;
    end

    // Hazards. A WB write to the destination always resolves WAW (its pending
    // bit is released this cycle); it resolves RAW only when the data is bypassed.
    always_comb begin
        wclr1    = RegWrite && (WriteReg == ReadReg1);
        wclr2    = RegWrite && (WriteReg == ReadReg2);
        wclr_iss = RegWrite && (WriteReg == IssueReg);
        rhaz1    = !is_zero(ReadReg1) && pending_q[ReadReg1] && !((BYPASS != 0) && wclr1);
        rhaz2    = !is_zero(ReadReg2) && pending_q[ReadReg2] && !((BYPASS != 0) && wclr2);
        whaz     = !is_zero(IssueReg) && pending_q[IssueReg] && !wclr_iss;
        Stall    = IssueValid && ((ReadEn1 && rhaz1) || (ReadEn2 && rhaz2) || whaz);
    end

    // Next state. Clear is applied before set so a same-register set wins.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        count_d   = count_q;
        set_v     = IssueValid && !Stall && !is_zero(IssueReg);
        clr_v     = RegWrite && pending_q[WriteReg] && !is_zero(WriteReg);

        if (RegWrite && !is_zero(WriteReg)) regs_d[WriteReg] = WriteData;
        if (clr_v) pending_d[WriteReg] = 1'b0;
        if (set_v) pending_d[IssueReg] = 1'b1;

        // Set and clear together (same or different register) leave the count as is.
        if (set_v && !clr_v)      count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
        else if (!set_v && clr_v) count_d = count_q - {{ADDR_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign PendingCount = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          reg_write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_reg1, read_reg2;
    logic          read_en1, read_en2;
    logic          issue_valid;
    logic [AW-1:0] issue_reg;

    logic [DW-1:0] rd1, rd2, rd1_nb, rd2_nb;
    logic          stall, stall_nb;
    logic [AW:0]   pcount, pcount_nb;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: register contents and the set of pending registers.
    logic [DW-1:0] m_regs [NR];
    bit            m_pend [NR];

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .RegWrite(reg_write), .WriteReg(write_reg), .WriteData(write_data),
        .ReadReg1(read_reg1), .ReadReg2(read_reg2), .ReadEn1(read_en1), .ReadEn2(read_en2),
        .IssueValid(issue_valid), .IssueReg(issue_reg),
        .ReadData1(rd1), .ReadData2(rd2), .Stall(stall), .PendingCount(pcount)
    );

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .RegWrite(reg_write), .WriteReg(write_reg), .WriteData(write_data),
        .ReadReg1(read_reg1), .ReadReg2(read_reg2), .ReadEn1(read_en1), .ReadEn2(read_en2),
        .IssueValid(issue_valid), .IssueReg(issue_reg),
        .ReadData1(rd1_nb), .ReadData2(rd2_nb), .Stall(stall_nb), .PendingCount(pcount_nb)
    );

    function automatic bit m_zero(input int r);
        return r == 0;
    endfunction

    function automatic logic [DW-1:0] m_read(input int r);
        if (m_zero(r)) return '0;
        if (reg_write && int'(write_reg) == r) return write_data;
        return m_regs[r];
    endfunction

    function automatic bit m_stall();
        bit h;
        int a1, a2, d;
        a1 = int'(read_reg1);
        a2 = int'(read_reg2);
        d  = int'(issue_reg);
        h = 0;
        if (read_en1 && !m_zero(a1) && m_pend[a1] && !(reg_write && int'(write_reg) == a1)) h = 1;
        if (read_en2 && !m_zero(a2) && m_pend[a2] && !(reg_write && int'(write_reg) == a2)) h = 1;
        if (!m_zero(d) && m_pend[d] && !(reg_write && int'(write_reg) == d)) h = 1;
        return issue_valid && h;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NR; i++) if (m_pend[i]) c++;
        return c;
    endfunction

    task automatic idle();
        rst = 0; reg_write = 0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0; read_en1 = 0; read_en2 = 0;
        issue_valid = 0; issue_reg = '0;
    endtask

    // One clock edge; the model advances from the same inputs the DUT sees.
    task automatic step();
        bit st, do_set;
        st = m_stall();
        do_set = issue_valid && !st && !m_zero(int'(issue_reg));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
        end else begin
            if (reg_write && !m_zero(int'(write_reg))) begin
                m_regs[write_reg] = write_data;
                m_pend[write_reg] = 0;
            end
            if (do_set) m_pend[issue_reg] = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; step(); idle(); #1;
        n_cmp++; if (pcount !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", pcount); end
        for (int r = 0; r < NR; r++) begin
            read_reg1 = r[AW-1:0]; #1;
            n_cmp++; if (rd1 !== '0) begin n_bad++; $display("FAIL reset_reg%0d: got %h want 0", r, rd1); end
        end
        idle();
    endtask

    task automatic test_zero_reg();
        idle(); reg_write = 1; write_reg = 0; write_data = 32'hDEADBEEF; read_reg1 = 0; #1;
        n_cmp++; if (rd1 !== '0) begin n_bad++; $display("FAIL zero_during_write: got %h want 0", rd1); end
        step();
        write_reg = 8; write_data = 32'h10; step();
        idle(); read_reg1 = 0; read_reg2 = 8; #1;
        n_cmp++; if (rd1 !== '0) begin n_bad++; $display("FAIL zero_r0: got %h want 0", rd1); end
        n_cmp++; if (rd2 !== 32'h10) begin n_bad++; $display("FAIL zero_r8: got %h want 10", rd2); end
        rst = 1; step(); rst = 0; #1;
        n_cmp++; if (rd1 !== '0) begin n_bad++; $display("FAIL zero_r0_post: got %h want 0", rd1); end
        n_cmp++; if (rd2 !== '0) begin n_bad++; $display("FAIL zero_r8_post: got %h want 0", rd2); end
        n_cmp++; if (pcount !== '0) begin n_bad++; $display("FAIL zero_count: got %0d want 0", pcount); end
    endtask

    task automatic test_bypass();
        idle(); reg_write = 1; write_reg = 9; write_data = 32'h11; step();
        write_data = 32'h55; read_reg1 = 9; #1;
        n_cmp++; if (rd1 !== 32'h55) begin n_bad++; $display("FAIL bypass_on: got %h want 55", rd1); end
        n_cmp++; if (rd1_nb !== 32'h11) begin n_bad++; $display("FAIL bypass_off_old: got %h want 11", rd1_nb); end
        step(); idle(); read_reg1 = 9; #1;
        n_cmp++; if (rd1_nb !== 32'h55) begin n_bad++; $display("FAIL bypass_off_new: got %h want 55", rd1_nb); end
    endtask

    task automatic test_raw();
        idle(); issue_valid = 1; issue_reg = 10; #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL raw_first_issue: got %b want 0", stall); end
        step();
        n_cmp++; if (pcount !== 6'd1) begin n_bad++; $display("FAIL raw_count: got %0d want 1", pcount); end
        issue_reg = 20; read_en1 = 1; read_reg1 = 10; #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall: got %b want 1", stall); end
        step();
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall_held: got %b want 1", stall); end
        reg_write = 1; write_reg = 10; write_data = 32'hA5A5_0F0F; #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL raw_release: got %b want 0", stall); end
        n_cmp++; if (rd1 !== 32'hA5A5_0F0F) begin n_bad++; $display("FAIL raw_bypass: got %h want a5a50f0f", rd1); end
        step();
        n_cmp++; if (pcount !== 6'd1) begin n_bad++; $display("FAIL raw_swap_count: got %0d want 1", pcount); end
        idle(); reg_write = 1; write_reg = 20; step(); idle(); #1;
        n_cmp++; if (pcount !== 6'd0) begin n_bad++; $display("FAIL raw_drain: got %0d want 0", pcount); end
    endtask

    task automatic test_waw();
        idle(); issue_valid = 1; issue_reg = 11; step(); #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL waw_stall: got %b want 1", stall); end
        step();
        n_cmp++; if (pcount !== 6'd1) begin n_bad++; $display("FAIL waw_count: got %0d want 1", pcount); end
        reg_write = 1; write_reg = 11; write_data = 32'h1234; #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL waw_release: got %b want 0", stall); end
        step();
        n_cmp++; if (pcount !== 6'd1) begin n_bad++; $display("FAIL waw_reissue_count: got %0d want 1", pcount); end
        reg_write = 0; #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL waw_bit_kept: got %b want 1", stall); end
        idle(); reg_write = 1; write_reg = 11; step(); idle(); #1;
        n_cmp++; if (pcount !== 6'd0) begin n_bad++; $display("FAIL waw_drain: got %0d want 0", pcount); end
    endtask

    task automatic test_simultaneous();
        idle(); issue_valid = 1; issue_reg = 12; step();
        issue_reg = 13; reg_write = 1; write_reg = 12; step();
        n_cmp++; if (pcount !== 6'd1) begin n_bad++; $display("FAIL sim_count: got %0d want 1", pcount); end
        idle(); issue_valid = 1; issue_reg = 12; #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sim_r12_free: got %b want 0", stall); end
        issue_reg = 13; #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sim_r13_pend: got %b want 1", stall); end
        issue_reg = 0; step();
        n_cmp++; if (pcount !== 6'd1) begin n_bad++; $display("FAIL sim_r0_issue: got %0d want 1", pcount); end
        idle(); reg_write = 1; write_reg = 13; step(); idle(); #1;
        n_cmp++; if (pcount !== 6'd0) begin n_bad++; $display("FAIL sim_drain: got %0d want 0", pcount); end
    endtask

    task automatic test_reset_mid();
        idle(); issue_valid = 1; issue_reg = 14; step(); issue_reg = 15; step();
        n_cmp++; if (pcount !== 6'd2) begin n_bad++; $display("FAIL mid_count2: got %0d want 2", pcount); end
        rst = 1; issue_reg = 16; step(); idle(); #1;
        n_cmp++; if (pcount !== 6'd0) begin n_bad++; $display("FAIL mid_count0: got %0d want 0", pcount); end
        for (int r = 14; r <= 16; r++) begin
            issue_valid = 1; read_en1 = 1; read_reg1 = r[AW-1:0]; issue_reg = r[AW-1:0]; #1;
            n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_stall_r%0d: got %b want 0", r, stall); end
        end
        idle();
    endtask

    task automatic test_random();
        logic [DW-1:0] e1, e2;
        bit es;
        int ec;
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 79) == 0);
            reg_write   = $urandom_range(0, 1) == 1;
            write_reg   = AW'($urandom_range(0, 7));
            write_data  = $urandom;
            read_reg1   = AW'($urandom_range(0, 7));
            read_reg2   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            read_en1    = $urandom_range(0, 1) == 1;
            read_en2    = $urandom_range(0, 1) == 1;
            issue_valid = $urandom_range(0, 2) != 0;
            issue_reg   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            #1;
            e1 = m_read(int'(read_reg1));
            e2 = m_read(int'(read_reg2));
            es = m_stall();
            ec = m_count();
            if (rd1 !== e1 || rd2 !== e2 || stall !== es || int'(pcount) != ec) begin
                n_bad++;
                $display("FAIL rand_%0d: rd1=%h/%h rd2=%h/%h stall=%b/%b count=%0d/%0d (got/want)",
                         n, rd1, e1, rd2, e2, stall, es, pcount, ec);
            end
            n_cmp++;
            step();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
        idle();
        @(negedge clk);
        test_reset();
        test_zero_reg();
        test_bypass();
        test_raw();
        test_waw();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
